jpeg_bit_window: RTL and testbench

Entropy-coded bitstream window for the baseline JPEG decoder. Accepts the scan's byte stream, removes 0xFF00 byte-stuffing, and keeps an MSB-aligned 32-bit window of pending bits. The MCU coefficient decoder consumes the window through a 6-bit variable-length pop. It sits directly upstream of the MCU processor: `outport_valid_o`/`outport_data_o` drive its `inport_valid_i`/`inport_data_i`, and its `inport_pop_o` drives `outport_pop_i`.

---
 rtl/jpeg_pkg.sv | 9 +
 rtl/jpeg_bit_window.sv | 99 +++++++++
 tb/tb_jpeg_bit_window.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/jpeg_pkg.sv
// Shared constants for the baseline JPEG decoder datapath.
package jpeg_pkg;

  localparam int          JPEG_BITBUF_W    = 64;
  localparam int          JPEG_WINDOW_W    = 32;
  localparam logic [7:0]  JPEG_MARKER_BYTE = 8'hFF;
  localparam logic [7:0]  JPEG_STUFF_BYTE  = 8'h00;

endpackage

// File: rtl/jpeg_bit_window.sv
// Entropy-coded bitstream window: removes 0xFF00 stuffing and keeps an
// MSB-aligned window of pending scan bits for the coefficient decoder.
module jpeg_bit_window
  import jpeg_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        img_start_i,
  input  logic        inport_valid_i,
  input  logic [7:0]  inport_data_i,
  input  logic        inport_last_i,
  output logic        inport_accept_o,
  output logic        outport_valid_o,
  output logic [31:0] outport_data_o,
  output logic        outport_last_o,
  input  logic [5:0]  outport_pop_i
);

  localparam logic [6:0] CNT_WINDOW   = 7'(JPEG_WINDOW_W);
  localparam logic [6:0] CNT_PUSH_MAX = 7'(JPEG_BITBUF_W - 8);
  localparam logic [6:0] CNT_BYTE     = 7'd8;

  // Unused LSBs of buf_q are always 1s, so the window tail reads as JPEG fill bits.
  logic [JPEG_BITBUF_W-1:0] buf_q;
  logic [JPEG_BITBUF_W-1:0] buf_pop;
  logic [JPEG_BITBUF_W-1:0] buf_d;
  logic [JPEG_BITBUF_W-1:0] byte_mask;
  logic [JPEG_BITBUF_W-1:0] byte_bits;
  logic [6:0]               count_q;
  logic [6:0]               count_pop;
  logic [6:0]               count_d;
  logic [6:0]               pop_eff;
  logic                     skip_q;
  logic                     skip_d;
  logic                     last_q;
  logic                     last_d;
  logic                     push_w;
  logic                     stuff_w;
  logic                     store_w;

  // Outputs depend on registered state only (accept also on img_start_i).
  always_comb begin
    outport_data_o  = buf_q[JPEG_BITBUF_W-1 -: JPEG_WINDOW_W];
    outport_valid_o = (count_q >= CNT_WINDOW) | (last_q & (count_q != 7'd0));
    outport_last_o  = last_q & (count_q <= CNT_WINDOW);
    inport_accept_o = !img_start_i & !last_q & (count_q <= CNT_PUSH_MAX);
  end

  // Pop shifter followed by byte insert at the first free bit position.
  always_comb begin
    pop_eff   = outport_valid_o ? {1'b0, outport_pop_i} : 7'd0;
    // Shift the inverted buffer so the vacated LSBs come back as 1s.
    buf_pop   = ~((~buf_q) << pop_eff);
    // An over-long pop is illegal; clamp rather than wrap the count.
    count_pop = (pop_eff > count_q) ? 7'd0 : (count_q - pop_eff);

    push_w    = inport_valid_i & inport_accept_o;
    stuff_w   = push_w & skip_q & (inport_data_i == JPEG_STUFF_BYTE);
    store_w   = push_w & !stuff_w;

    byte_mask = {8'hFF, {(JPEG_BITBUF_W-8){1'b0}}} >> count_pop;
    byte_bits = {inport_data_i, {(JPEG_BITBUF_W-8){1'b0}}} >> count_pop;

    buf_d   = buf_pop;
    count_d = count_pop;
    skip_d  = skip_q;
    if (store_w) begin
      buf_d   = (buf_pop & ~byte_mask) | byte_bits;
      count_d = count_pop + CNT_BYTE;
      skip_d  = (inport_data_i == JPEG_MARKER_BYTE);
    end else if (stuff_w) begin
      skip_d  = 1'b0;
    end
    // A discarded stuffing byte can still carry the end-of-scan flag.
    last_d = last_q | (push_w & inport_last_i);
  end

  // State register; reset and image start both flush the window.
  always_ff @(posedge clk_i) begin
    if (rst_i || img_start_i) begin
      buf_q   <= '1;
      count_q <= 7'd0;
      skip_q  <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      buf_q   <= buf_d;
      count_q <= count_d;
      skip_q  <= skip_d;
      last_q  <= last_d;
    end
  end

  // Consumer must never pop more bits than the window holds.
  pop_within_count: assert property (
    @(posedge clk_i) disable iff (rst_i || img_start_i)
    outport_valid_o |-> ({1'b0, outport_pop_i} <= count_q)
  );

endmodule

// File: tb/tb_jpeg_bit_window.sv
// Scoreboard bench for jpeg_bit_window against a bit-queue reference model.
module tb_jpeg_bit_window;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        img_start_i = 1'b0;
  logic        inport_valid_i = 1'b0;
  logic [7:0]  inport_data_i = 8'h00;
  logic        inport_last_i = 1'b0;
  logic        inport_accept_o;
  logic        outport_valid_o;
  logic [31:0] outport_data_o;
  logic        outport_last_o;
  logic [5:0]  outport_pop_i = 6'd0;

  jpeg_bit_window dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .img_start_i     (img_start_i),
    .inport_valid_i  (inport_valid_i),
    .inport_data_i   (inport_data_i),
    .inport_last_i   (inport_last_i),
    .inport_accept_o (inport_accept_o),
    .outport_valid_o (outport_valid_o),
    .outport_data_o  (outport_data_o),
    .outport_last_o  (outport_last_o),
    .outport_pop_i   (outport_pop_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        v;
    logic        l;
    logic        a;
    logic [31:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model: the pending scan bits in arrival order.
  bit   mbits[$];
  bit   mskip = 1'b0;
  bit   mlast = 1'b0;

  function automatic bit m_valid();
    return (mbits.size() >= 32) || (mlast && mbits.size() != 0);
  endfunction

  function automatic logic [31:0] m_window();
    logic [31:0] w;
    for (int i = 0; i < 32; i++)
      w[31-i] = (i < mbits.size()) ? mbits[i] : 1'b1;
    return w;
  endfunction

  task automatic m_clear();
    mbits.delete();
    mskip = 1'b0;
    mlast = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, got, want);
    end
  endtask

  // Monitor: compare every presented cycle against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("valid",  32'(outport_valid_o), 32'(e.v));
        check("last",   32'(outport_last_o),  32'(e.l));
        check("accept", 32'(inport_accept_o), 32'(e.a));
        check("data",   outport_data_o,       e.d);
      end
    end
  end

  // Drive one cycle, queue the expected outputs, then advance the model.
  task automatic step(input bit r, input bit img, input bit iv, input logic [7:0] b,
                      input bit il, input int pop);
    exp_t e;
    bit   acc;
    rst_i          = r;
    img_start_i    = img;
    inport_valid_i = iv;
    inport_data_i  = b;
    inport_last_i  = il;
    outport_pop_i  = 6'(pop);
    e.v = m_valid();
    e.l = mlast && (mbits.size() <= 32);
    e.a = !img && !mlast && (mbits.size() <= 56);
    e.d = m_window();
    exp_q.push_back(e);
    @(posedge clk_i);
    #1;
    if (r || img) begin
      m_clear();
    end else begin
      acc = e.a && iv;
      if (e.v)
        for (int k = 0; k < pop; k++) void'(mbits.pop_front());
      if (acc) begin
        if (mskip && b == 8'h00) begin
          mskip = 1'b0;
        end else begin
          for (int k = 7; k >= 0; k--) mbits.push_back(b[k]);
          mskip = (b == 8'hFF);
        end
        if (il) mlast = 1'b1;
      end
    end
  endtask

  task automatic push(input logic [7:0] b, input bit il);
    step(1'b0, 1'b0, 1'b1, b, il, 0);
  endtask

  task automatic idle(input int pop);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, pop);
  endtask

  task automatic restart();
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 0);
  endtask

  initial begin
    bit prev_pop;
    int hi;
    int pop;
    bit r;
    bit img;
    bit iv;
    bit il;
    logic [7:0] b;
    int sel;

    @(posedge clk_i);
    #1;
    m_clear();
    // Reset values
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 0);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 0);

    // Basic fill and a 4-bit pop
    push(8'h12, 1'b0); push(8'h34, 1'b0); push(8'h56, 1'b0); push(8'h78, 1'b0);
    push(8'h9A, 1'b0);
    idle(4);
    idle(0);

    // Reset held mid-traffic
    step(1'b1, 1'b0, 1'b1, 8'h55, 1'b0, 0);
    step(1'b1, 1'b0, 1'b1, 8'h55, 1'b0, 0);
    step(1'b1, 1'b0, 1'b1, 8'h55, 1'b0, 0);
    idle(0);

    // Byte stuffing, then FF D9 marker bytes both stored
    push(8'hFF, 1'b0); push(8'h00, 1'b0); push(8'hAB, 1'b0); push(8'hCD, 1'b0);
    push(8'hEE, 1'b0);
    idle(0);
    push(8'hFF, 1'b0); push(8'hD9, 1'b0);
    idle(0);

    // End of scan: single byte, drain, accept stays low
    restart();
    push(8'hA5, 1'b1);
    idle(0);
    idle(8);
    push(8'h11, 1'b0); push(8'h22, 1'b0);
    restart();
    idle(0);

    // Full boundary
    for (int i = 1; i <= 7; i++) push(8'(i * 8'h11), 1'b0);
    push(8'h88, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'h99, 1'b0, 0);
    step(1'b0, 1'b0, 1'b1, 8'h99, 1'b0, 8);
    step(1'b0, 1'b0, 1'b1, 8'h99, 1'b0, 0);
    idle(0);

    // Image start overrides push/pop with last set
    restart();
    push(8'h01, 1'b0); push(8'h02, 1'b0); push(8'h03, 1'b0); push(8'h04, 1'b0);
    push(8'h05, 1'b1);
    step(1'b0, 1'b1, 1'b1, 8'h77, 1'b0, 8);
    idle(0);

    // Randomized traffic
    prev_pop = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      r   = ($urandom_range(0, 299) == 0);
      img = ($urandom_range(0, 149) == 0) ||
            (mlast && mbits.size() == 0 && $urandom_range(0, 3) == 0);
      iv  = ($urandom_range(0, 9) < 7);
      sel = $urandom_range(0, 7);
      b   = (sel == 0) ? 8'hFF : (sel == 1) ? 8'h00 : 8'($urandom);
      il  = ($urandom_range(0, 199) == 0);
      pop = 0;
      if (m_valid() && !prev_pop && $urandom_range(0, 1) == 1) begin
        hi  = (mbits.size() < 32) ? mbits.size() : 32;
        pop = $urandom_range(0, hi);
      end
      prev_pop = (pop != 0);
      step(r, img, iv, b, il, pop);
    end

    idle(0);
    @(negedge clk_i);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
